pc_sequencer: RTL

- Run-control sequencer for the RISC_V_Processor program counter.
- Owns the PC register and drives the processor's hold control (pc_control: 1 = hold PC).
- Provides halt, run, N-instruction single-step, jump-load and one hardware breakpoint.
- Sits between the debug/bench stimulus and the processor core; replaces hand-toggled pc_control/pc_in.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Run-control sequencer: owns the processor PC and decides each cycle whether the
// instruction at pc executes (run, N-step, halt, jump-load, one hardware breakpoint).
module pc_sequencer #(
    parameter int PC_W     = 8,
    parameter int PC_INC   = 1,
    parameter int PC_RESET = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [7:0]       step_n,
    input  logic             jump_valid,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             cnt_clr,
    output logic [PC_W-1:0]  pc,
    output logic             pc_control,
    output logic             exec_en,
    output logic             halted,
    output logic             jump_ack,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rem_q;
    logic             exec_q;
    logic             jump_ack_q;
    logic             step_done_q;
    logic             bp_hit_q;
    logic             bp_match;

    // The breakpoint is checked against the address about to execute next, so a
    // resume from pc==bp_addr executes that instruction without re-hitting.
    assign pc_d     = pc_q + PC_W'(PC_INC);
    assign bp_match = bp_en && (pc_d == bp_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HALT;
            pc_q        <= PC_W'(PC_RESET);
            cnt_q       <= '0;
            rem_q       <= '0;
            exec_q      <= 1'b0;
            jump_ack_q  <= 1'b0;
            step_done_q <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            jump_ack_q  <= 1'b0;
            step_done_q <= 1'b0;

            if (exec_q) begin
                pc_q <= pc_d;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (exec_q) begin
                cnt_q <= cnt_q + 1'b1;
            end

            case (state_q)
                S_HALT: begin
                    if (halt_req) begin
                        state_q <= S_HALT;
                    end else if (jump_valid) begin
                        pc_q       <= jump_addr;
                        jump_ack_q <= 1'b1;
                    end else if (step_req) begin
                        rem_q    <= (step_n == 8'd0) ? 8'd1 : step_n;
                        state_q  <= S_STEP;
                        exec_q   <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end else if (run_req) begin
                        state_q  <= S_RUN;
                        exec_q   <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        state_q <= S_HALT;
                        exec_q  <= 1'b0;
                    end else if (bp_match) begin
                        state_q  <= S_HALT;
                        exec_q   <= 1'b0;
                        bp_hit_q <= 1'b1;
                    end
                end
                S_STEP: begin
                    rem_q <= rem_q - 8'd1;
                    if (halt_req) begin
                        state_q <= S_HALT;
                        exec_q  <= 1'b0;
                        rem_q   <= '0;
                    end else if (rem_q == 8'd1 || bp_match) begin
                        state_q     <= S_HALT;
                        exec_q      <= 1'b0;
                        rem_q       <= '0;
                        step_done_q <= (rem_q == 8'd1);
                        bp_hit_q    <= bp_hit_q | bp_match;
                    end
                end
                default: begin
                    state_q <= S_HALT;
                    exec_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign exec_en     = exec_q;
    assign pc_control  = ~exec_q;
    assign halted      = ~exec_q;
    assign jump_ack    = jump_ack_q;
    assign step_done   = step_done_q;
    assign bp_hit      = bp_hit_q;
    assign retired_cnt = cnt_q;

endmodule
